// File: rtl/miner_pkg.sv
// Shared constants and types for the miner's UART framing path.
// The header receiver and the nonce transmitter both import this package.
package miner_pkg;

    localparam int HEADER_BYTES = 80;
    localparam int HEADER_BITS  = HEADER_BYTES * 8;
    localparam int NONCE_BYTES  = 4;

    localparam int CLOCK_HZ = 50_000_000;
    // Longest idle gap allowed between two bytes of one frame: 20 ms of clock.
    localparam int TIMEOUT_CYCLES = CLOCK_HZ / 50;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        WAIT_CLR = 2'd2
    } hdr_rx_state_t;

endpackage

// File: rtl/uart_header_rx_if.sv
// Byte handshake between the UART receiver (master) and the header framer (slave).
// The master presents data and a ready level; the slave answers with a clear request.
interface uart_header_rx_if;

    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rdy_clr;

    modport master (
        output rx_data,
        output rx_ready,
        input  rdy_clr
    );

    modport slave (
        input  rx_data,
        input  rx_ready,
        output rdy_clr
    );

endinterface

// File: rtl/gap_timer.sv
// Idle-gap counter: clears on clr, counts while en, saturates at LIMIT.
// expire flags the cycle whose edge brings the count up to LIMIT.
module gap_timer #(
    parameter int LIMIT = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_W  = W'(LIMIT);
    localparam logic [W-1:0] LIMIT_M1 = W'(LIMIT - 1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en && (count_reg != LIMIT_W)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expire = en && !clr && (count_reg >= LIMIT_M1);

endmodule

// File: rtl/uart_header_rx.sv
// Assembles HEADER_BYTES received UART bytes into one block header, first byte in the MSBs.
// Partial frames that stall longer than TIMEOUT_CYCLES are dropped with a frame_error pulse.
module uart_header_rx
    import miner_pkg::*;
#(
    parameter int HEADER_BYTES   = miner_pkg::HEADER_BYTES,
    parameter int TIMEOUT_CYCLES = miner_pkg::TIMEOUT_CYCLES
) (
    input  logic                        clock,
    input  logic                        reset,
    uart_header_rx_if.slave             rx,
    output logic [8*HEADER_BYTES-1:0]   header_data,
    output logic                        header_valid,
    output logic                        frame_error,
    output logic [6:0]                  byte_count,
    output logic                        busy
);

    localparam int HBITS = 8 * HEADER_BYTES;
    // The last byte goes straight into the header, so staging only holds the bytes before it.
    localparam int SBITS = 8 * (HEADER_BYTES - 1);
    localparam logic [6:0] LAST_INDEX = 7'(HEADER_BYTES - 1);

    hdr_rx_state_t    state_reg, state_next;
    logic [SBITS-1:0] staging_reg, staging_next;
    logic [HBITS-1:0] header_data_reg, header_data_next;
    logic [6:0]       byte_count_reg, byte_count_next;
    logic             header_valid_reg, header_valid_next;
    logic             frame_error_reg, frame_error_next;
    logic             rdy_clr_reg, rdy_clr_next;

    logic             capture;
    logic             last_byte;
    logic             timer_en;
    logic             timer_clr;
    logic             timer_expire;
    logic [SBITS-1:0] staging_shifted;

    assign staging_shifted[7:0] = rx.rx_data;
    for (genvar gi = 1; gi < HEADER_BYTES - 1; gi++) begin : g_lane
        assign staging_shifted[8*gi +: 8] = staging_reg[8*(gi-1) +: 8];
    end

    assign capture   = ((state_reg == IDLE) || (state_reg == RECV)) && rx.rx_ready;
    assign last_byte = (byte_count_reg == LAST_INDEX);
    assign timer_en  = (state_reg == RECV);
    assign timer_clr = capture || (state_reg != RECV);

    gap_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clock  (clock),
        .reset  (reset),
        .clr    (timer_clr),
        .en     (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        state_next        = state_reg;
        staging_next      = staging_reg;
        header_data_next  = header_data_reg;
        byte_count_next   = byte_count_reg;
        header_valid_next = 1'b0;
        frame_error_next  = 1'b0;
        rdy_clr_next      = rdy_clr_reg;

        case (state_reg)
            IDLE, RECV: begin
                if (capture) begin
                    rdy_clr_next = 1'b1;
                    state_next   = WAIT_CLR;
                    if (last_byte) begin
                        header_data_next  = {staging_reg, rx.rx_data};
                        header_valid_next = 1'b1;
                        byte_count_next   = '0;
                        staging_next      = '0;
                    end else begin
                        staging_next    = staging_shifted;
                        byte_count_next = byte_count_reg + 7'd1;
                    end
                end else if (timer_expire) begin
                    frame_error_next = 1'b1;
                    byte_count_next  = '0;
                    staging_next     = '0;
                    state_next       = IDLE;
                end
            end
            WAIT_CLR: begin
                // Hold the clear request until the receiver has actually dropped ready.
                if (!rx.rx_ready) begin
                    rdy_clr_next = 1'b0;
                    state_next   = (byte_count_reg == 7'd0) ? IDLE : RECV;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            staging_reg      <= '0;
            header_data_reg  <= '0;
            byte_count_reg   <= '0;
            header_valid_reg <= 1'b0;
            frame_error_reg  <= 1'b0;
            rdy_clr_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            staging_reg      <= staging_next;
            header_data_reg  <= header_data_next;
            byte_count_reg   <= byte_count_next;
            header_valid_reg <= header_valid_next;
            frame_error_reg  <= frame_error_next;
            rdy_clr_reg      <= rdy_clr_next;
        end
    end

    assign header_data  = header_data_reg;
    assign header_valid = header_valid_reg;
    assign frame_error  = frame_error_reg;
    assign byte_count   = byte_count_reg;
    assign busy         = (byte_count_reg != 7'd0);
    assign rx.rdy_clr   = rdy_clr_reg;

endmodule

// File: tb/tb_uart_header_rx.sv
// Randomized bench for uart_header_rx against a byte-queue model of the framing rules.
// Uses a short gap timeout so stall and expiry-race cases stay cheap to simulate.
module tb_uart_header_rx;

    localparam int TMO   = 100;
    localparam int HB    = 80;
    localparam int HBITS = HB * 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    uart_header_rx_if rx_if ();

    logic [HBITS-1:0] header_data;
    logic             header_valid;
    logic             frame_error;
    logic [6:0]       byte_count;
    logic             busy;

    uart_header_rx #(
        .HEADER_BYTES   (HB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx_if),
        .header_data  (header_data),
        .header_valid (header_valid),
        .frame_error  (frame_error),
        .byte_count   (byte_count),
        .busy         (busy)
    );

    int total = 0;
    int bad   = 0;

    // Pulse monitors
    int   hv_seen = 0, fe_seen = 0, clr_rises = 0, hv_wide = 0, fe_wide = 0;
    logic hv_prev = 1'b0, fe_prev = 1'b0, clr_prev = 1'b0;
    always @(negedge clock) begin
        if (header_valid === 1'b1) hv_seen++;
        if (frame_error === 1'b1) fe_seen++;
        if (header_valid === 1'b1 && hv_prev) hv_wide++;
        if (frame_error === 1'b1 && fe_prev) fe_wide++;
        if (rx_if.rdy_clr === 1'b1 && !clr_prev) clr_rises++;
        hv_prev  = (header_valid === 1'b1);
        fe_prev  = (frame_error === 1'b1);
        clr_prev = (rx_if.rdy_clr === 1'b1);
    end

    // Reference model: bytes of the current partial frame and the last complete header
    logic [7:0]       model_q[$];
    logic [HBITS-1:0] model_header = '0;
    int               model_hv = 0, model_fe = 0, model_clr = 0;

    function automatic void model_push(input logic [7:0] b);
        model_q.push_back(b);
        model_clr++;
        if (model_q.size() == HB) begin
            for (int i = 0; i < HB; i++) model_header[HBITS-1-8*i -: 8] = model_q[i];
            model_q.delete();
            model_hv++;
        end
    endfunction

    function automatic void model_timeout();
        model_q.delete();
        model_fe++;
    endfunction

    function automatic void model_reset();
        model_q.delete();
        model_header = '0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        got = 1'b0;
        rx_if.rx_data  = b;
        rx_if.rx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (rx_if.rdy_clr === 1'b1) begin got = 1'b1; break; end
        end
        model_push(b);
        total++;
        if (!got) begin
            bad++;
            $display("FAIL byte_capture: rdy_clr=%b required 1 (data %h)", rx_if.rdy_clr, b);
        end
        total++;
        if (byte_count !== 7'(model_q.size())) begin
            bad++;
            $display("FAIL byte_count_after_capture: got %0d required %0d", byte_count, model_q.size());
        end
        rx_if.rx_ready = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (rx_if.rdy_clr === 1'b0) begin got = 1'b1; break; end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rdy_clr_release: rdy_clr=%b required 0", rx_if.rdy_clr);
        end
        repeat (gap) @(negedge clock);
    endtask

    task automatic send_random(input int n, input int maxgap);
        for (int i = 0; i < n; i++)
            send_byte(8'($urandom), (i == n - 1) ? 0 : int'($urandom_range(0, maxgap)));
    endtask

    task automatic do_reset();
        @(negedge clock);
        rx_if.rx_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({header_data, header_valid, frame_error, byte_count, busy, rx_if.rdy_clr} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: bc=%0d busy=%b hv=%b fe=%b clr=%b required all 0",
                     byte_count, busy, header_valid, frame_error, rx_if.rdy_clr);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        rx_if.rx_data  = 8'h3C;
        rx_if.rx_ready = 1'b1;
        @(negedge clock);
        model_push(8'h3C);
        total++;
        if (rx_if.rdy_clr !== 1'b1 || byte_count !== 7'd1) begin
            bad++;
            $display("FAIL reset_precondition: clr=%b bc=%0d required 1/1", rx_if.rdy_clr, byte_count);
        end
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        model_reset();
        total++;
        if (rx_if.rdy_clr !== 1'b0 || byte_count !== 7'd0 || busy !== 1'b0 || header_data !== model_header) begin
            bad++;
            $display("FAIL async_reset: clr=%b bc=%0d busy=%b required 0/0/0", rx_if.rdy_clr, byte_count, busy);
        end
        rx_if.rx_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_full_frame();
        logic [7:0] frame [HB];
        int         hv0;
        logic [7:0] head [8];
        logic [7:0] tail [4];
        head = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h81, 8'hcd, 8'h02, 8'hab};
        tail = '{8'h42, 8'h80, 8'h46, 8'h95};
        for (int i = 0; i < HB; i++) frame[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) frame[i] = head[i];
        for (int i = 0; i < 4; i++) frame[HB-4+i] = tail[i];
        #1 hv0 = hv_seen;
        for (int i = 0; i < HB; i++) send_byte(frame[i], int'($urandom_range(2, 60)));
        repeat (3) @(negedge clock);
        #1;
        total++;
        if (header_data !== model_header) begin
            bad++;
            $display("FAIL full_frame_header: got %h required %h", header_data[63:0], model_header[63:0]);
        end
        total++;
        if (header_data[HBITS-1 -: 32] !== 32'h01000000 || header_data[31:0] !== 32'h42804695) begin
            bad++;
            $display("FAIL full_frame_ends: got %h..%h required 01000000..42804695",
                     header_data[HBITS-1 -: 32], header_data[31:0]);
        end
        total++;
        if (hv_seen - hv0 != 1 || hv_wide != 0) begin
            bad++;
            $display("FAIL full_frame_valid: pulses %0d wide %0d required 1/0", hv_seen - hv0, hv_wide);
        end
        total++;
        if (byte_count !== 7'd0 || busy !== 1'b0 || clr_rises != model_clr) begin
            bad++;
            $display("FAIL full_frame_counts: bc=%0d busy=%b clr_pulses=%0d required 0/0/%0d",
                     byte_count, busy, clr_rises, model_clr);
        end
    endtask

    task automatic test_handshake();
        int clr0;
        #1 clr0 = clr_rises;
        rx_if.rx_data  = 8'hA5;
        rx_if.rx_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            total++;
            if (rx_if.rdy_clr !== 1'b1) begin
                bad++;
                $display("FAIL handshake_clr_held: cycle %0d rdy_clr=%b required 1", k, rx_if.rdy_clr);
            end
        end
        model_push(8'hA5);
        rx_if.rx_ready = 1'b0;
        @(negedge clock);
        total++;
        if (rx_if.rdy_clr !== 1'b0) begin
            bad++;
            $display("FAIL handshake_clr_drop: rdy_clr=%b required 0", rx_if.rdy_clr);
        end
        total++;
        if (byte_count !== 7'(model_q.size())) begin
            bad++;
            $display("FAIL handshake_single_capture: bc=%0d required %0d", byte_count, model_q.size());
        end
        repeat (2) @(negedge clock);
        #1;
        total++;
        if (clr_rises - clr0 != 1) begin
            bad++;
            $display("FAIL handshake_clr_pulses: got %0d required 1", clr_rises - clr0);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        int hit;
        send_random(HB, 30);
        send_random(10, 30);
        hit = 0;
        for (int i = 1; i <= 2 * TMO; i++) begin
            @(negedge clock);
            if (frame_error === 1'b1) begin hit = i; break; end
        end
        model_timeout();
        total++;
        if (hit != TMO) begin
            bad++;
            $display("FAIL timeout_latency: error after %0d cycles required %0d", hit, TMO);
        end
        repeat (3) @(negedge clock);
        #1;
        total++;
        if (byte_count !== 7'd0 || busy !== 1'b0 || header_data !== model_header) begin
            bad++;
            $display("FAIL timeout_state: bc=%0d busy=%b header %h required 0/0/%h",
                     byte_count, busy, header_data[31:0], model_header[31:0]);
        end
        total++;
        if (fe_seen != model_fe || fe_wide != 0) begin
            bad++;
            $display("FAIL timeout_pulse: pulses %0d wide %0d required %0d/0", fe_seen, fe_wide, model_fe);
        end
        send_random(HB, 30);
        repeat (2) @(negedge clock);
        total++;
        if (header_data !== model_header) begin
            bad++;
            $display("FAIL frame_after_timeout: got %h required %h", header_data[31:0], model_header[31:0]);
        end
    endtask

    task automatic test_expiry_race();
        send_random(3, 30);
        repeat (TMO - 1) @(negedge clock);
        send_byte(8'($urandom), 0);
        repeat (3) @(negedge clock);
        #1;
        total++;
        if (fe_seen != model_fe) begin
            bad++;
            $display("FAIL race_no_error: error pulses %0d required %0d", fe_seen, model_fe);
        end
        total++;
        if (byte_count !== 7'(model_q.size())) begin
            bad++;
            $display("FAIL race_count: bc=%0d required %0d", byte_count, model_q.size());
        end
        send_random(HB - 4, 20);
        repeat (2) @(negedge clock);
        total++;
        if (header_data !== model_header || hv_seen != model_hv) begin
            bad++;
            $display("FAIL race_frame: header %h pulses %0d required %h/%0d",
                     header_data[31:0], hv_seen, model_header[31:0], model_hv);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_random(40, 10);
        total++;
        if (busy !== 1'b1 || byte_count !== 7'(model_q.size())) begin
            bad++;
            $display("FAIL mid_frame_busy: busy=%b bc=%0d required 1/%0d", busy, byte_count, model_q.size());
        end
        do_reset();
        total++;
        if (header_data !== model_header || byte_count !== 7'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_frame_reset: header %h bc=%0d busy=%b required 0/0/0",
                     header_data[31:0], byte_count, busy);
        end
    endtask

    task automatic test_back_to_back();
        int hv0;
        #1 hv0 = hv_seen;
        send_random(HB, 5);
        for (int i = 0; i < HB; i++) begin
            send_byte(8'($urandom), int'($urandom_range(0, 5)));
            total++;
            if (header_data !== model_header) begin
                bad++;
                $display("FAIL b2b_header_hold: byte %0d header %h required %h",
                         i, header_data[31:0], model_header[31:0]);
            end
        end
        repeat (2) @(negedge clock);
        #1;
        total++;
        if (hv_seen - hv0 != 2 || hv_wide != 0) begin
            bad++;
            $display("FAIL b2b_valid_pulses: got %0d wide %0d required 2/0", hv_seen - hv0, hv_wide);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rx_if.rx_data  = 8'h00;
        rx_if.rx_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_handshake();
        test_timeout();
        test_expiry_race();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
